uart_rx: RTL

- 8N1 UART receiver, the receive-side counterpart of the FSM-based Tx block in UART/FSM.
- Oversamples the asynchronous serial line `rx` and locates each bit centre with a start-bit qualifier.
- Assembles LSB-first data bytes and presents each byte with a one-cycle `valid` strobe plus framing status.
- Sits between the board RX pin and the byte consumer (loopback checker or FIFO).

---
 rtl/uart_rx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronizes rx, qualifies the start bit at mid-bit, samples each bit at its centre.
// Define UART_RX_PARITY_EN for 8E1 framing with an extra parity_err strobe output.
module uart_rx #(
   parameter int CLKS_PER_BIT = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
`ifdef UART_RX_PARITY_EN
   output logic       parity_err,
`endif
   output logic       bussy
);

   localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);
   localparam logic [7:0] HALF_LAST = 8'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {HOLD, IDLE, START_BIT, READ_GPIO, PARITY_BIT, STOP_BIT} state_t;
`else
   typedef enum logic [2:0] {HOLD, IDLE, START_BIT, READ_GPIO, STOP_BIT} state_t;
`endif

   state_t                 state_q;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;
   logic [7:0]             cnt_q;
   logic [7:0]             cnt_d;
   logic [2:0]             bit_cnt_q;
   logic [2:0]             bit_cnt_d;
   logic [7:0]             shift_q;
   logic [7:0]             shift_d;
   logic [7:0]             data_q;
   logic                   valid_q;
   logic                   frame_err_q;
   logic                   bussy_q;
`ifdef UART_RX_PARITY_EN
   logic                   par_q;
   logic                   parity_err_q;
`endif

   // Synchronizer resets to idle-high so a reset never looks like a start bit
   always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '1;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
   end

   assign rxs       = sync_q[SYNC_STAGES-1];
   assign cnt_d     = cnt_q + 8'd1;
   assign bit_cnt_d = bit_cnt_q + 3'd1;
   assign shift_d   = {rxs, shift_q[7:1]};

   always_ff @(posedge clk) begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      if (!rst_n) begin
         state_q   <= HOLD;
         data_q    <= 8'h00;
         bussy_q   <= 1'b0;
         cnt_q     <= 8'd0;
         bit_cnt_q <= 3'd0;
      end else if (!ena) begin
         state_q   <= HOLD;
         bussy_q   <= 1'b0;
         cnt_q     <= 8'd0;
         bit_cnt_q <= 3'd0;
      end else begin
         case (state_q)
            HOLD: begin
               if (rxs) state_q <= IDLE;
            end
            IDLE: begin
               bussy_q <= 1'b0;
               if (!rxs) begin
                  state_q <= START_BIT;
                  cnt_q   <= 8'd0;
                  bussy_q <= 1'b1;
               end
            end
            START_BIT: begin
               if (cnt_q == HALF_LAST) begin
                  cnt_q     <= 8'd0;
                  bit_cnt_q <= 3'd0;
                  if (!rxs) begin
                     state_q <= READ_GPIO;
                  end else begin
                     state_q <= IDLE;
                     bussy_q <= 1'b0;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            READ_GPIO: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q     <= 8'd0;
                  shift_q   <= shift_d;
                  bit_cnt_q <= bit_cnt_d;
                  if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state_q <= PARITY_BIT;
`else
                     state_q <= STOP_BIT;
`endif
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY_BIT: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q   <= 8'd0;
                  par_q   <= rxs;
                  state_q <= STOP_BIT;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
`endif
            STOP_BIT: begin
               if (cnt_q == BIT_LAST) begin
                  cnt_q   <= 8'd0;
                  state_q <= IDLE;
                  bussy_q <= 1'b0;
                  // A low stop bit suppresses every other strobe and leaves data untouched
                  if (rxs) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
`ifdef UART_RX_PARITY_EN
                     parity_err_q <= ^{shift_q, par_q};
`endif
                  end else begin
                     frame_err_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            default: state_q <= HOLD;
         endcase
      end
   end

   assign data      = data_q;
   assign valid     = valid_q;
   assign frame_err = frame_err_q;
   assign bussy     = bussy_q;
`ifdef UART_RX_PARITY_EN
   assign parity_err = parity_err_q;
`endif

endmodule
